// File: rtl/csr_exec_unit.sv
// csr_exec_unit
//
// Execution stage for Zicsr instructions (CSRRW/CSRRS/CSRRC and the
// immediate forms). It sits directly upstream of the CSR register file.
// One request is accepted in IDLE. The old CSR value is sampled from the
// register file's combinational read port in READ. At most one write is
// issued in WRITE. The old value is returned for rd writeback in RESP.
//
// Ports
//   clk, rst                     clock, asynchronous active-high reset
//   req_valid / req_ready        request handshake
//   req_funct3                   001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI
//   req_csr_addr                 target CSR
//   req_rs1_field                rs1 index (register forms) or zimm (immediate forms)
//   req_rs1_data                 rs1 value, unused by immediate forms
//   csr_raddr / csr_rdata        register file read port (combinational data)
//   csr_waddr / csr_wdata        register file write port
//   csr_web                      write enable, active-high, one cycle pulse
//   resp_valid / resp_ready      response handshake
//   resp_rd_data                 old CSR value, zero when illegal
//   resp_illegal                 illegal-instruction flag for this request

module csr_exec_unit #(
  parameter int XLEN   = 64,
  parameter int CSR_AW = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_funct3,
  input  logic [CSR_AW-1:0] req_csr_addr,
  input  logic [4:0]        req_rs1_field,
  input  logic [XLEN-1:0]   req_rs1_data,
  output logic [CSR_AW-1:0] csr_raddr,
  input  logic [XLEN-1:0]   csr_rdata,
  output logic [CSR_AW-1:0] csr_waddr,
  output logic [XLEN-1:0]   csr_wdata,
  output logic              csr_web,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_rd_data,
  output logic              resp_illegal
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]        state_q;
  logic [2:0]        funct3_q;
  logic [CSR_AW-1:0] addr_q;
  logic [4:0]        rs1_field_q;
  logic [XLEN-1:0]   rs1_data_q;
  logic [XLEN-1:0]   old_q;
  logic [XLEN-1:0]   new_q;
  logic              wr_en_q;
  logic              illegal_q;

  logic              accept;
  logic [XLEN-1:0]   src;
  logic [XLEN-1:0]   new_val;
  logic              wr_req;
  logic              illegal;

  // Immediate forms take the 5-bit zimm zero-extended; register forms take rs1.
  function automatic logic [XLEN-1:0] csr_src(
    input logic [2:0]      f3,
    input logic [4:0]      zimm,
    input logic [XLEN-1:0] rs1
  );
    if (f3[2]) begin
      return {{(XLEN-5){1'b0}}, zimm};
    end
    return rs1;
  endfunction

  // Pure bitwise update, no carries between bits.
  function automatic logic [XLEN-1:0] csr_update(
    input logic [1:0]      op,
    input logic [XLEN-1:0] old_val,
    input logic [XLEN-1:0] s
  );
    case (op)
      2'b01:   return s;
      2'b10:   return old_val | s;
      default: return old_val & ~s;
    endcase
  endfunction

  // Set/clear with rs1/zimm of zero is a pure read. Swaps always write.
  function automatic logic csr_wants_write(
    input logic [1:0] op,
    input logic [4:0] rs1_field
  );
    return (op == 2'b01) || (rs1_field != 5'd0);
  endfunction

  // funct3 x00 is not a CSR op. Any write into the top quadrant is illegal
  // because that quadrant is read-only.
  function automatic logic csr_is_illegal(
    input logic [1:0] op,
    input logic       wants_write,
    input logic [1:0] addr_top
  );
    return (op == 2'b00) || (wants_write && (addr_top == 2'b11));
  endfunction

  assign accept  = (state_q == IDLE) && req_valid;
  assign src     = csr_src(funct3_q, rs1_field_q, rs1_data_q);
  assign new_val = csr_update(funct3_q[1:0], csr_rdata, src);
  assign wr_req  = csr_wants_write(funct3_q[1:0], rs1_field_q);
  assign illegal = csr_is_illegal(funct3_q[1:0], wr_req,
                                  addr_q[CSR_AW-1:CSR_AW-2]);

  // The FSM and the request latch share one register stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      funct3_q    <= 3'd0;
      addr_q      <= '0;
      rs1_field_q <= 5'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            funct3_q    <= req_funct3;
            addr_q      <= req_csr_addr;
            rs1_field_q <= req_rs1_field;
            state_q     <= READ;
          end
        end
        READ:    state_q <= WRITE;
        WRITE:   state_q <= RESP;
        RESP: begin
          if (resp_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // rs1 data is only consumed after a fresh accept, so it needs no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      rs1_data_q <= req_rs1_data;
    end
  end

  // Result stage: sampled in READ, held through WRITE and RESP so the
  // response stays stable under back-pressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      old_q     <= '0;
      new_q     <= '0;
      wr_en_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else if (state_q == READ) begin
      old_q     <= illegal ? '0 : csr_rdata;
      new_q     <= new_val;
      wr_en_q   <= wr_req && !illegal;
      illegal_q <= illegal;
    end
  end

  // The write enable is decoded from the state. An asynchronous reset in
  // WRITE therefore removes the pulse at once.
  assign req_ready    = (state_q == IDLE);
  assign resp_valid   = (state_q == RESP);
  assign csr_web      = (state_q == WRITE) && wr_en_q;
  assign csr_raddr    = addr_q;
  assign csr_waddr    = addr_q;
  assign csr_wdata    = new_q;
  assign resp_rd_data = old_q;
  assign resp_illegal = illegal_q;

endmodule

// File: tb/tb_csr_exec_unit.sv
module tb_csr_exec_unit;

  localparam int XLEN   = 64;
  localparam int CSR_AW = 12;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [2:0]        req_funct3 = 3'd0;
  logic [CSR_AW-1:0] req_csr_addr = '0;
  logic [4:0]        req_rs1_field = 5'd0;
  logic [XLEN-1:0]   req_rs1_data = '0;
  logic [CSR_AW-1:0] csr_raddr;
  logic [XLEN-1:0]   csr_rdata;
  logic [CSR_AW-1:0] csr_waddr;
  logic [XLEN-1:0]   csr_wdata;
  logic              csr_web;
  logic              resp_valid;
  logic              resp_ready = 1'b1;
  logic [XLEN-1:0]   resp_rd_data;
  logic              resp_illegal;

  int checks = 0;
  int errors = 0;

  csr_exec_unit #(.XLEN(XLEN), .CSR_AW(CSR_AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_funct3   (req_funct3),
    .req_csr_addr (req_csr_addr),
    .req_rs1_field(req_rs1_field),
    .req_rs1_data (req_rs1_data),
    .csr_raddr    (csr_raddr),
    .csr_rdata    (csr_rdata),
    .csr_waddr    (csr_waddr),
    .csr_wdata    (csr_wdata),
    .csr_web      (csr_web),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rd_data (resp_rd_data),
    .resp_illegal (resp_illegal)
  );

  always #5 clk = ~clk;

  // CSR register file model: combinational read, write at the clock edge.
  logic [XLEN-1:0]   rf [0:4095];
  logic              pl_en = 1'b0;
  logic [CSR_AW-1:0] pl_addr = '0;
  logic [XLEN-1:0]   pl_data = '0;
  int                web_cnt = 0;

  always @(posedge clk) begin
    if (pl_en) rf[pl_addr] <= pl_data;
    else if (csr_web) rf[csr_waddr] <= csr_wdata;
  end
  always @(posedge clk) if (csr_web) web_cnt <= web_cnt + 1;
  assign csr_rdata = rf[csr_raddr];

  // Observations from the last run_req call.
  logic            obs_web_read, obs_web_write, obs_rdy_read, obs_rv;
  logic [XLEN-1:0] obs_wdata, obs_rd;
  logic [CSR_AW-1:0] obs_waddr;
  logic            obs_ill;
  int              obs_web_delta;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [CSR_AW-1:0] a, input logic [XLEN-1:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (!req_ready) begin
      errors++;
      $display("FAIL ready_timeout req_ready=%0b required 1", req_ready);
    end
  endtask

  // Drives one request with resp_ready high and records each stage.
  task automatic run_req(input logic [2:0] f3, input logic [CSR_AW-1:0] a,
                         input logic [4:0] f, input logic [XLEN-1:0] d);
    int w0;
    w0 = web_cnt;
    req_valid = 1'b1; req_funct3 = f3; req_csr_addr = a;
    req_rs1_field = f; req_rs1_data = d;
    wait_ready();
    tick();                        // accept edge, now READ
    req_valid = 1'b0;
    obs_web_read = csr_web;
    obs_rdy_read = req_ready;
    tick();                        // WRITE
    obs_web_write = csr_web;
    obs_wdata = csr_wdata;
    obs_waddr = csr_waddr;
    tick();                        // RESP
    obs_rv  = resp_valid;
    obs_rd  = resp_rd_data;
    obs_ill = resp_illegal;
    tick();                        // handshake, back to IDLE
    obs_web_delta = web_cnt - w0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready got %0b want 1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid got %0b want 0", resp_valid); end
    checks++; if (resp_illegal !== 1'b0) begin errors++; $display("FAIL rst_resp_illegal got %0b want 0", resp_illegal); end
    checks++; if (csr_web !== 1'b0) begin errors++; $display("FAIL rst_csr_web got %0b want 0", csr_web); end
    checks++; if (resp_rd_data !== 64'h0) begin errors++; $display("FAIL rst_rd_data got %h want 0", resp_rd_data); end
    checks++; if (csr_raddr !== 12'h0 || csr_waddr !== 12'h0) begin errors++; $display("FAIL rst_addr got %h/%h want 0/0", csr_raddr, csr_waddr); end
    checks++; if (csr_wdata !== 64'h0) begin errors++; $display("FAIL rst_wdata got %h want 0", csr_wdata); end
    rst = 1'b0;
    tick();
    checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("FAIL post_rst_idle got rdy=%0b rv=%0b want 1/0", req_ready, resp_valid); end
  endtask

  task automatic test_rw_mscratch();
    preload(12'h340, 64'h0);
    run_req(3'b001, 12'h340, 5'd5, 64'hDEAD_BEEF);
    checks++; if (obs_web_read !== 1'b0 || obs_rdy_read !== 1'b0) begin errors++; $display("FAIL rw_read_cycle got web=%0b rdy=%0b want 0/0", obs_web_read, obs_rdy_read); end
    checks++; if (obs_web_write !== 1'b1) begin errors++; $display("FAIL rw_web got %0b want 1", obs_web_write); end
    checks++; if (obs_wdata !== 64'hDEAD_BEEF || obs_waddr !== 12'h340) begin errors++; $display("FAIL rw_wdata got %h@%h want deadbeef@340", obs_wdata, obs_waddr); end
    checks++; if (obs_rv !== 1'b1 || obs_rd !== 64'h0 || obs_ill !== 1'b0) begin errors++; $display("FAIL rw_resp got v=%0b rd=%h ill=%0b want 1/0/0", obs_rv, obs_rd, obs_ill); end
    checks++; if (obs_web_delta != 1) begin errors++; $display("FAIL rw_web_count got %0d want 1", obs_web_delta); end
    run_req(3'b010, 12'h340, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    checks++; if (obs_rd !== 64'hDEAD_BEEF) begin errors++; $display("FAIL rs0_rd got %h want deadbeef", obs_rd); end
    checks++; if (obs_web_write !== 1'b0 || obs_web_delta != 0) begin errors++; $display("FAIL rs0_nowrite got web=%0b cnt=%0d want 0/0", obs_web_write, obs_web_delta); end
  endtask

  task automatic test_set_clear();
    preload(12'h341, 64'hF0);
    run_req(3'b110, 12'h341, 5'h15, 64'hFFFF_0000_FFFF_0000);
    checks++; if (obs_web_write !== 1'b1 || obs_wdata !== 64'hF5 || obs_rd !== 64'hF0) begin errors++; $display("FAIL rsi got web=%0b wd=%h rd=%h want 1/f5/f0", obs_web_write, obs_wdata, obs_rd); end
    run_req(3'b111, 12'h341, 5'h10, 64'h0);
    checks++; if (obs_web_write !== 1'b1 || obs_wdata !== 64'hE5 || obs_rd !== 64'hF5) begin errors++; $display("FAIL rci got web=%0b wd=%h rd=%h want 1/e5/f5", obs_web_write, obs_wdata, obs_rd); end
    run_req(3'b011, 12'h341, 5'd3, 64'hF);
    checks++; if (obs_wdata !== 64'hE0 || obs_rd !== 64'hE5) begin errors++; $display("FAIL rc_reg got wd=%h rd=%h want e0/e5", obs_wdata, obs_rd); end
    run_req(3'b010, 12'h341, 5'd7, 64'h8000_0000_0000_0001);
    checks++; if (obs_wdata !== 64'h8000_0000_0000_00E1 || obs_rd !== 64'hE0) begin errors++; $display("FAIL rs_reg got wd=%h rd=%h want 80000000000000e1/e0", obs_wdata, obs_rd); end
    run_req(3'b101, 12'h341, 5'd0, 64'hABCD);
    checks++; if (obs_web_write !== 1'b1 || obs_wdata !== 64'h0 || obs_rd !== 64'h8000_0000_0000_00E1) begin errors++; $display("FAIL rwi_zero got web=%0b wd=%h rd=%h want 1/0/80000000000000e1", obs_web_write, obs_wdata, obs_rd); end
  endtask

  task automatic test_illegal();
    preload(12'hF15, 64'h1234);
    preload(12'hF14, 64'h0);
    run_req(3'b001, 12'hF15, 5'd1, 64'h5555);
    checks++; if (obs_ill !== 1'b1 || obs_rd !== 64'h0) begin errors++; $display("FAIL ro_write got ill=%0b rd=%h want 1/0", obs_ill, obs_rd); end
    checks++; if (obs_web_write !== 1'b0 || obs_web_delta != 0) begin errors++; $display("FAIL ro_write_web got web=%0b cnt=%0d want 0/0", obs_web_write, obs_web_delta); end
    run_req(3'b010, 12'hF14, 5'd0, 64'h0);
    checks++; if (obs_ill !== 1'b0 || obs_rd !== 64'h0 || obs_web_delta != 0) begin errors++; $display("FAIL hartid_read got ill=%0b rd=%h cnt=%0d want 0/0/0", obs_ill, obs_rd, obs_web_delta); end
    run_req(3'b011, 12'hF15, 5'd0, 64'hFF);
    checks++; if (obs_ill !== 1'b0 || obs_rd !== 64'h1234) begin errors++; $display("FAIL ro_read got ill=%0b rd=%h want 0/1234", obs_ill, obs_rd); end
    run_req(3'b100, 12'h340, 5'd1, 64'h1);
    checks++; if (obs_ill !== 1'b1 || obs_rd !== 64'h0 || obs_web_delta != 0) begin errors++; $display("FAIL f3_100 got ill=%0b rd=%h cnt=%0d want 1/0/0", obs_ill, obs_rd, obs_web_delta); end
    run_req(3'b000, 12'h340, 5'd0, 64'h1);
    checks++; if (obs_ill !== 1'b1 || obs_rd !== 64'h0 || obs_web_delta != 0) begin errors++; $display("FAIL f3_000 got ill=%0b rd=%h cnt=%0d want 1/0/0", obs_ill, obs_rd, obs_web_delta); end
  endtask

  task automatic test_backpressure();
    logic [XLEN-1:0] rd0;
    logic stable;
    resp_ready = 1'b0;
    req_valid = 1'b1; req_funct3 = 3'b001; req_csr_addr = 12'h340;
    req_rs1_field = 5'd1; req_rs1_data = 64'h1111;
    wait_ready();
    tick();                          // A accepted
    req_funct3 = 3'b010; req_rs1_field = 5'd0; req_rs1_data = 64'h0;
    tick(); tick();                  // RESP
    rd0 = resp_rd_data;
    checks++; if (resp_valid !== 1'b1 || rd0 !== 64'hDEAD_BEEF) begin errors++; $display("FAIL bp_first got v=%0b rd=%h want 1/deadbeef", resp_valid, rd0); end
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (resp_valid !== 1'b1 || resp_rd_data !== rd0 || req_ready !== 1'b0 ||
          csr_web !== 1'b0 || resp_illegal !== 1'b0) stable = 1'b0;
    end
    checks++; if (!stable) begin errors++; $display("FAIL bp_hold got stable=%0b want 1", stable); end
    resp_ready = 1'b1;
    tick();                          // handshake, IDLE
    checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("FAIL bp_idle got rdy=%0b rv=%0b want 1/0", req_ready, resp_valid); end
    tick();                          // B accepted
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_accept got rdy=%0b want 0", req_ready); end
    req_valid = 1'b0;
    tick(); tick();
    checks++; if (resp_valid !== 1'b1 || resp_rd_data !== 64'h1111) begin errors++; $display("FAIL bp_second got v=%0b rd=%h want 1/1111", resp_valid, resp_rd_data); end
    tick();
  endtask

  task automatic test_reset_mid_write();
    int w0;
    preload(12'h342, 64'hAA);
    w0 = web_cnt;
    req_valid = 1'b1; req_funct3 = 3'b001; req_csr_addr = 12'h342;
    req_rs1_field = 5'd1; req_rs1_data = 64'h55;
    wait_ready();
    tick();                          // READ
    req_valid = 1'b0;
    tick();                          // WRITE
    checks++; if (csr_web !== 1'b1) begin errors++; $display("FAIL mid_pre_web got %0b want 1", csr_web); end
    rst = 1'b1;
    #1;
    checks++; if (csr_web !== 1'b0) begin errors++; $display("FAIL mid_web_drop got %0b want 0", csr_web); end
    tick();
    rst = 1'b0;
    tick();
    checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("FAIL mid_after got rdy=%0b rv=%0b want 1/0", req_ready, resp_valid); end
    checks++; if (web_cnt != w0) begin errors++; $display("FAIL mid_no_write got %0d want %0d", web_cnt, w0); end
    run_req(3'b010, 12'h342, 5'd0, 64'h0);
    checks++; if (obs_rd !== 64'hAA) begin errors++; $display("FAIL mid_csr_kept got %h want aa", obs_rd); end
  endtask

  initial begin
    test_reset();
    test_rw_mscratch();
    test_set_clear();
    test_illegal();
    test_backpressure();
    test_reset_mid_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached, simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/csr_exec_unit.md
# csr_exec_unit

Execution stage for Zicsr instructions (CSRRW/CSRRS/CSRRC and immediate variants) that sits directly upstream of the CSR register file. It accepts one decoded CSR request over a valid/ready handshake. It reads the old CSR value through the register file's read port, computes the new value, and issues at most one write through the write port. It then returns the old value for rd writeback over a second valid/ready handshake.

## Interface
- XLEN, pkg_parameters::XLEN (64): data width.
- CSR_AW, 12: CSR address width.
- clk  in  1  clock; also drives the CSR register file write port.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit idle and able to accept.
- req_funct3  in  3  instruction funct3: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI.
- req_csr_addr  in  CSR_AW  target CSR.
- req_rs1_field  in  5  rs1 index (register forms) or zimm (immediate forms).
- req_rs1_data  in  XLEN  rs1 register value; ignored for immediate forms.
- csr_raddr  out  CSR_AW  to register file read address.
- csr_rdata  in  XLEN  combinational read data from register file.
- csr_waddr  out  CSR_AW  to register file write address.
- csr_wdata  out  XLEN  write data.
- csr_web  out  1  write enable, active-high (1 = write).
- resp_valid  out  1  result present.
- resp_ready  in  1  downstream accepts result.
- resp_rd_data  out  XLEN  old CSR value (zero when illegal).
- resp_illegal  out  1  request raised illegal-instruction.

## Operation
- FSM states: IDLE, READ, WRITE, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch funct3, addr, rs1_field and rs1_data, then go to READ.
- READ:
  - Drive csr_raddr from the latched address.
  - Register csr_rdata into old_q.
  - Compute new_q and wr_en_q, then go to WRITE.
- WRITE:
  - csr_web=wr_en_q for exactly this cycle.
  - csr_waddr is the latched address; csr_wdata is new_q.
  - Go to RESP.
- RESP:
  - resp_valid=1; hold outputs stable until resp_ready.
  - On resp_valid && resp_ready, go to IDLE.
- Source operand src:
  - Immediate forms (funct3[2]=1): zero-extended 5-bit zimm.
  - Register forms: req_rs1_data.
- New value:
  - RW/RWI: src.
  - RS/RSI: old | src.
  - RC/RCI: old & ~src.
  - All operations are XLEN wide, no carries.
- Write suppression:
  - RS, RSI, RC and RCI do not write when rs1_field==0.
  - RW and RWI always write.
- Illegal:
  - funct3 of 000 or 100, or
  - a write is required and req_csr_addr[11:10]==2'b11 (read-only space).
  - On illegal: wr_en_q=0, resp_illegal=1, resp_rd_data=0.
- A read is always performed, including RW with rd=x0. Side-effect-free reads are acceptable.
- csr_raddr and csr_waddr output the latched address in every state. They are 0 after reset until the first accept.

## Timing
- Reset values: req_ready=1, resp_valid=0, resp_illegal=0, csr_web=0, resp_rd_data=0, csr_raddr=0, csr_waddr=0, csr_wdata=0, FSM=IDLE.
- Latency: a request accepted at edge N produces:
  - READ in cycle N+1;
  - a write pulse in cycle N+2, committed at the edge ending N+2;
  - resp_valid from cycle N+3.
- The minimum initiation interval is 4 cycles.
- req_ready is 0 in READ, WRITE and RESP. The unit never accepts a new request in the same cycle as a response handshake; the next accept is in the IDLE cycle after.
- Back-pressure: resp_ready low holds RESP indefinitely with all outputs stable, and csr_web stays 0.
- Self-modifying counters (mcycle): the returned value is the counter during the READ cycle. A write in WRITE overrides that cycle's increment.
- Reset asserted mid-operation:
  - The FSM returns to IDLE asynchronously.
  - csr_web drops to 0 immediately, so no partial write occurs.
  - Any pending response is discarded.

## Test plan
- CSRRW to MSCRATCH (0x340) holding 0x0, rs1_data=0xDEAD_BEEF, rs1_field=5:
  - csr_web pulses once at N+2 with wdata 0xDEADBEEF.
  - resp_rd_data=0 at N+3.
  - A following CSRRS with rs1_field=0 returns 0xDEADBEEF and does not write.
- CSRRSI mask 0x15 on a CSR holding 0xF0, then CSRRCI 0x10:
  - Writes 0xF5, then 0xE5.
  - Responses return 0xF0, then 0xF5.
- CSRRW to MCONFIGPTR (0xF15):
  - resp_illegal=1 and resp_rd_data=0.
  - csr_web never asserted.
- CSRRS with rs1_field=0 on MHARTID (0xF14): legal read, resp_rd_data=0, no write. funct3=100: illegal.
- Hold resp_ready=0 for 10 cycles with req_valid=1 continuously:
  - resp_valid and data stay stable; req_ready stays 0.
  - After release, the second request is accepted exactly 1 cycle later.
- Assert rst during the WRITE state:
  - csr_web is 0 that cycle and the CSR is unchanged.
  - After deassert, req_ready=1 and resp_valid=0.
